// File: rtl/updown_counter_n.sv
// updown_counter_n: parametrised synchronous up/down counter with parallel
// load, count enable, wrap/saturate mode, combinational terminal count and
// a registered one-cycle wrap pulse.
//
// Optional feature, compiled in when the macro UDCNT_STICKY_EN is defined:
// adds input wrap_clr and output wrap_sticky, a flag that latches any wrap
// pulse until it is explicitly cleared.
//
// Arithmetic is modulo (MAX_COUNT+1). The increment and decrement are formed
// in WIDTH+1 bits, so MAX_COUNT = 2**WIDTH-1 needs no special case.
module updown_counter_n #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ud,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
`ifdef UDCNT_STICKY_EN
  ,
  input  logic             wrap_clr,
  output logic             wrap_sticky
`endif
);

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MAX_COUNT);
  localparam logic [WIDTH:0]   ONE_EXT = (WIDTH + 1)'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic             up_over;
  logic             down_under;
  logic             at_max;
  logic             at_zero;

  // Widened neighbours of the current count and the bound conditions.
  always_comb begin
    inc_ext    = {1'b0, cnt_q} + ONE_EXT;
    dec_ext    = {1'b0, cnt_q} - ONE_EXT;
    // q never exceeds MAX_COUNT, so stepping past it means q sat at the top.
    up_over    = (inc_ext > MAX_EXT);
    // Borrow out of the widened subtract means q was 0.
    down_under = dec_ext[WIDTH];
    at_max     = (cnt_q == MAX_Q);
    at_zero    = (cnt_q == '0);
  end

  // Next count and wrap flag: load beats enable, enable beats hold.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the if/else tree can leave it unassigned and infer a latch.
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (load) begin
      cnt_d = ({1'b0, load_val} > MAX_EXT) ? MAX_Q : load_val;
    end else if (en) begin
      if (ud) begin
        if (!up_over) begin
          cnt_d = inc_ext[WIDTH-1:0];
        end else if (!SATURATE) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (!down_under) begin
          cnt_d = dec_ext[WIDTH-1:0];
        end else if (!SATURATE) begin
          cnt_d  = MAX_Q;
          wrap_d = 1'b1;
        end
      end
    end
  end

  // Count and wrap registers; reset clears both without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments here, so every register samples the
    // values from before the edge regardless of statement order.
    if (!rst_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  // Terminal count: this stage is about to roll over (or is pinned) this edge.
  always_comb begin
    tc = en & ~load & ((ud & at_max) | (~ud & at_zero));
  end

  assign q    = cnt_q;
  assign wrap = wrap_q;

`ifdef UDCNT_STICKY_EN
  logic sticky_q, sticky_d;

  // Sticky flag: set together with wrap; a clear in the same cycle loses.
  always_comb begin
    sticky_d = wrap_d | (sticky_q & ~wrap_clr);
  end

  // Sticky flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign wrap_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_updown_counter_n.sv
// Self-checking bench for updown_counter_n. Three instances share stimulus:
//   0: MAX_COUNT=9,  wrap mode
//   1: MAX_COUNT=9,  saturate mode
//   2: MAX_COUNT=15 (default), wrap mode
// An arithmetic model per instance is compared on every falling edge, and
// directed sequences pin the model with hand-computed literal values.
module tb_updown_counter_n;

  localparam int N = 3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       ud;
  logic       load;
  logic [3:0] load_val;
  logic       wrap_clr;

  logic [3:0] q_w, q_s, q_f;
  logic       tc_w, tc_s, tc_f;
  logic       wrap_w, wrap_s, wrap_f;
  logic       stk_w, stk_s, stk_f;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  int max_of [N] = '{9, 9, 15};
  bit sat_of [N] = '{1'b0, 1'b1, 1'b0};

  int m_q [N];
  bit m_w [N];
  bit m_s [N];

  updown_counter_n #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .ud(ud), .load(load),
    .load_val(load_val), .q(q_w), .tc(tc_w), .wrap(wrap_w)
`ifdef UDCNT_STICKY_EN
    , .wrap_clr(wrap_clr), .wrap_sticky(stk_w)
`endif
  );

  updown_counter_n #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .ud(ud), .load(load),
    .load_val(load_val), .q(q_s), .tc(tc_s), .wrap(wrap_s)
`ifdef UDCNT_STICKY_EN
    , .wrap_clr(wrap_clr), .wrap_sticky(stk_s)
`endif
  );

  updown_counter_n #(.WIDTH(4)) dut_f (
    .clk(clk), .rst_n(rst_n), .en(en), .ud(ud), .load(load),
    .load_val(load_val), .q(q_f), .tc(tc_f), .wrap(wrap_f)
`ifdef UDCNT_STICKY_EN
    , .wrap_clr(wrap_clr), .wrap_sticky(stk_f)
`endif
  );

`ifndef UDCNT_STICKY_EN
  assign stk_w = 1'b0;
  assign stk_s = 1'b0;
  assign stk_f = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: count modulo (max+1); saturate pins at the bounds.
  function automatic int model_next_q(int k, int cur);
    int mx;
    mx = max_of[k];
    if (load) return (int'(load_val) > mx) ? mx : int'(load_val);
    if (!en) return cur;
    if (ud) begin
      if (cur == mx && sat_of[k]) return cur;
      return (cur + 1) % (mx + 1);
    end
    if (cur == 0 && sat_of[k]) return cur;
    return (cur + mx) % (mx + 1);
  endfunction

  function automatic bit model_next_w(int k, int cur);
    if (load || !en || sat_of[k]) return 1'b0;
    return ud ? (cur == max_of[k]) : (cur == 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        m_q[k] <= 0;
        m_w[k] <= 1'b0;
        m_s[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        m_q[k] <= model_next_q(k, m_q[k]);
        m_w[k] <= model_next_w(k, m_q[k]);
        m_s[k] <= model_next_w(k, m_q[k]) | (m_s[k] & ~wrap_clr);
      end
    end
  end

  function automatic bit model_tc(int k);
    return en && !load && ((ud && m_q[k] == max_of[k]) || (!ud && m_q[k] == 0));
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("q_w",    int'(q_w),    m_q[0]);
      check("q_s",    int'(q_s),    m_q[1]);
      check("q_f",    int'(q_f),    m_q[2]);
      check("wrap_w", int'(wrap_w), int'(m_w[0]));
      check("wrap_s", int'(wrap_s), int'(m_w[1]));
      check("wrap_f", int'(wrap_f), int'(m_w[2]));
      check("tc_w",   int'(tc_w),   int'(model_tc(0)));
      check("tc_s",   int'(tc_s),   int'(model_tc(1)));
      check("tc_f",   int'(tc_f),   int'(model_tc(2)));
`ifdef UDCNT_STICKY_EN
      check("stk_w",  int'(stk_w),  int'(m_s[0]));
      check("stk_s",  int'(stk_s),  int'(m_s[1]));
      check("stk_f",  int'(stk_f),  int'(m_s[2]));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_up   [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp_down [4]  = '{1, 0, 9, 8};

  initial begin
    rst_n    = 1'b1;
    en       = 1'b0;
    ud       = 1'b1;
    load     = 1'b0;
    load_val = '0;
    wrap_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset q_w",    int'(q_w),    0);
    check("reset wrap_w", int'(wrap_w), 0);
    check("reset tc_w",   int'(tc_w),   0);
    check("reset q_f",    int'(q_f),    0);
    chk_on = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;

    // Up count through the wrap.
    en = 1'b1;
    ud = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("up q",    int'(q_w),    exp_up[i]);
      check("up wrap", int'(wrap_w), (i == 9) ? 1 : 0);
      check("up tc",   int'(tc_w),   (exp_up[i] == 9) ? 1 : 0);
    end

    // Load 2, then count down through the wrap.
    load = 1'b1; load_val = 4'd2; en = 1'b0;
    tick();
    check("load2 q", int'(q_w), 2);
    load = 1'b0; en = 1'b1; ud = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("down q",    int'(q_w),    exp_down[i]);
      check("down wrap", int'(wrap_w), (i == 2) ? 1 : 0);
      check("down tc",   int'(tc_w),   (exp_down[i] == 0) ? 1 : 0);
    end

    // Load priority and clamp.
    load = 1'b1; load_val = 4'hC; en = 1'b1; ud = 1'b1;
    tick();
    check("clamp q_w",    int'(q_w),    9);
    check("clamp wrap_w", int'(wrap_w), 0);
    check("clamp tc_w",   int'(tc_w),   0);
    check("clamp q_f",    int'(q_f),    12);
    load_val = 4'd3;
    tick();
    check("load prio q_w", int'(q_w), 3);

    // Saturate instance pinned at the top, then at the bottom.
    load_val = 4'd8;
    tick();
    load = 1'b0; en = 1'b1; ud = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat up q",    int'(q_s),    9);
      check("sat up wrap", int'(wrap_s), 0);
      check("sat up tc",   int'(tc_s),   1);
    end
    load = 1'b1; load_val = 4'd1;
    tick();
    load = 1'b0; ud = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat dn q",    int'(q_s),    0);
      check("sat dn wrap", int'(wrap_s), 0);
      check("sat dn tc",   int'(tc_s),   1);
    end

    // Asynchronous reset mid-count at q=6.
    load = 1'b1; load_val = 4'd5;
    tick();
    load = 1'b0; en = 1'b1; ud = 1'b1;
    tick();
    check("pre-rst q", int'(q_w), 6);
    #2 rst_n = 1'b0;
    #1;
    check("async q",    int'(q_w),    0);
    check("async wrap", int'(wrap_w), 0);
    #2 rst_n = 1'b1;
    tick();
    check("resume q", int'(q_w), 1);

    // Asynchronous reset clears a live wrap pulse.
    load = 1'b1; load_val = 4'd9;
    tick();
    load = 1'b0;
    tick();
    check("wrap live", int'(wrap_w), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async wrap clr", int'(wrap_w), 0);
    #2 rst_n = 1'b1;
    tick();
    check("resume2 q", int'(q_w), 1);

`ifdef UDCNT_STICKY_EN
    // Sticky wrap flag: set, hold, set-beats-clear, clear.
    load = 1'b1; load_val = 4'd9; en = 1'b1; ud = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("stk set", int'(stk_w), 1);
    tick();
    check("stk hold", int'(stk_w), 1);
    load = 1'b1;
    tick();
    load = 1'b0; wrap_clr = 1'b1;
    tick();
    check("stk set wins", int'(stk_w), 1);
    en = 1'b0;
    tick();
    check("stk clr", int'(stk_w), 0);
    wrap_clr = 1'b0;
`endif

    // Randomised phase with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      load     = ($urandom_range(0, 7) == 0);
      en       = ($urandom_range(0, 3) != 0);
      ud       = 1'($urandom_range(0, 1));
      load_val = 4'($urandom_range(0, 15));
      wrap_clr = ($urandom_range(0, 7) == 0);
      rst_n    = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
